// File: rtl/ray_rx.sv
// ray_rx: 8-bit asynchronous serial receiver with a one-entry holding register.
// Frame: start (low), 8 data bits LSB first, optional even parity, one stop (high).
// Each bit is sampled once, at its midpoint, timed from the synchronized start edge.
//
// Optional feature: define RAY_RX_PARITY_EN to add the even-parity bit and parity_err.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   rxd        - asynchronous serial input, idle high
//   rx_data    - received byte, valid while rx_valid=1
//   rx_valid   - holding register contains an unread byte
//   rx_ready   - consumer accepts the byte when rx_valid & rx_ready
//   frame_err  - one-cycle pulse on a low stop bit
//   overrun    - one-cycle pulse when a good byte is dropped (holding register full)
//   parity_err - one-cycle pulse on parity mismatch (tied 0 without RAY_RX_PARITY_EN)
module ray_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

`ifdef RAY_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q;
  logic            rxd_s1, rxd_s2, rxd_prev;
  logic            fall, bit_tick, half_tick;
  logic            shift_en, stop_smp, par_bad, good, load, valid_d;
`ifdef RAY_RX_PARITY_EN
  logic            par_smp, par_bad_q;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  assign fall      = rxd_prev & ~rxd_s2;
  assign cnt_inc   = cnt_q + CntW'(1);
  assign bit_tick  = (cnt_q == BitLast);
  assign half_tick = (cnt_q == HalfLast);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (fall) state_d = StStart;
      StStart:  if (half_tick) state_d = rxd_s2 ? StIdle : StData;
`ifdef RAY_RX_PARITY_EN
      StData:   if (bit_tick && bit_q == 3'd7) state_d = StParity;
      StParity: if (bit_tick) state_d = StStop;
`else
      StData:   if (bit_tick && bit_q == 3'd7) state_d = StStop;
`endif
      StStop:   if (bit_tick) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Counter and sampling strobes.
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_en = 1'b0;
    stop_smp = 1'b0;
`ifdef RAY_RX_PARITY_EN
    par_smp  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
      end
      // Start mid-sample restarts the count so data samples land mid-bit.
      StStart: cnt_d = half_tick ? '0 : cnt_inc;
      StData: begin
        cnt_d = bit_tick ? '0 : cnt_inc;
        if (bit_tick) begin
          shift_en = 1'b1;
          bit_d    = bit_q + 3'd1;
        end
      end
`ifdef RAY_RX_PARITY_EN
      StParity: begin
        cnt_d   = bit_tick ? '0 : cnt_inc;
        par_smp = bit_tick;
      end
`endif
      StStop: begin
        cnt_d    = bit_tick ? '0 : cnt_inc;
        stop_smp = bit_tick;
      end
      default: cnt_d = '0;
    endcase
  end

`ifdef RAY_RX_PARITY_EN
  // Even parity: data bits xor parity bit must be 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (par_smp) par_bad_q <= rxd_s2 ^ (^shift_q);
      parity_err <= stop_smp & par_bad_q;
    end
  end
  assign par_bad = par_bad_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign good    = stop_smp & rxd_s2 & ~par_bad;
  // Accept and load in the same cycle: new byte replaces old, valid stays high.
  assign load    = good & (~rx_valid | rx_ready);
  assign valid_d = load | (rx_valid & ~rx_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      if (shift_en) shift_q <= {rxd_s2, shift_q[7:1]};
      if (load) rx_data <= shift_q;
      rx_valid  <= valid_d;
      frame_err <= stop_smp & ~rxd_s2;
      overrun   <= good & rx_valid & ~rx_ready;
    end
  end

endmodule

// File: doc/ray_rx.md
RAY_RX -- requirements
Module: ray_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per serial bit; legal range is an even number from 4 to 1024.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port rxd, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port rx_data, output, 8 bits: received byte, valid while rx_valid=1.
REQ-006 The block SHALL have port rx_valid, output, 1 bit: the holding register contains an unread byte.
REQ-007 The block SHALL have port rx_ready, input, 1 bit: consumer accepts the byte when rx_valid and rx_ready are both 1.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a bad stop bit is received.
REQ-009 The block SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the holding register is full.
REQ-010 The block SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch; constant 0 when RAY_RX_PARITY_EN is not defined.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, and STOP; PARITY is reachable only with RAY_RX_PARITY_EN.
REQ-013 IDLE->START SHALL occur on a synchronized 1->0 edge, and the bit counter SHALL clear.
REQ-014 In START, the line SHALL be sampled at count CLKS_PER_BIT/2-1: low -> DATA; high -> IDLE (glitch rejected, no flags).
REQ-015 In DATA, 8 bits SHALL be sampled LSB first, one every CLKS_PER_BIT cycles after the start mid-sample.
REQ-016 After the 8th bit, the FSM SHALL go to PARITY if enabled, else to STOP, sampling each one bit period later.
REQ-017 In STOP, a low sample SHALL pulse frame_err, discard the byte, and return to IDLE.
REQ-018 In STOP, a high sample SHALL go to IDLE and deliver the byte per REQ-019 to REQ-021.
REQ-019 A byte SHALL be delivered by loading the holding register if rx_valid=0 or rx_ready=1 that cycle, with rx_valid=1 on the next cycle.
REQ-020 If the holding register is full and rx_ready=0, the block SHALL pulse overrun, drop the new byte, and keep the held byte unchanged.
REQ-021 When accept and load happen in the same cycle, the new byte SHALL replace the old one, rx_valid SHALL stay 1, and no overrun SHALL occur.
REQ-022 rx_valid SHALL fall the cycle after accept if no load occurs; rx_data SHALL be stable while rx_valid=1.
REQ-023 A new falling edge SHALL be detected only in IDLE, so back-to-back frames with a single stop bit are received.
REQ-024 Bit and sample counters SHALL be sized for CLKS_PER_BIT; no counter wraps within a frame.

Reset
REQ-025 While rst_n=0, the block SHALL force: FSM to IDLE, counters to 0, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, parity_err=0, synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL resume only on a fresh falling edge.

Configuration
REQ-027 Macro RAY_RX_PARITY_EN defined: the frame SHALL be start, 8 data bits, even parity, stop.
REQ-028 With RAY_RX_PARITY_EN, a parity mismatch SHALL pulse parity_err in the cycle after the stop sample, and the byte SHALL be discarded.
REQ-029 With RAY_RX_PARITY_EN and both errors present, frame_err and parity_err SHALL pulse together.
REQ-030 Macro RAY_RX_PARITY_EN undefined: the frame SHALL be start, 8 data bits, stop; parity_err SHALL be tied to 0 and no PARITY state logic SHALL exist.

Verification
REQ-031 Frame 0xA5, CLKS_PER_BIT=16, rx_ready=1 -> rx_data=0xA5, rx_valid high exactly 1 cycle, within 156 cycles of the falling edge.
REQ-032 Low pulse of 5 cycles on rxd -> no rx_valid, no flags, FSM back in IDLE.
REQ-033 Frames 0x3C then 0xC3 back to back with rx_ready=0 -> rx_data stays 0x3C, one overrun pulse; then rx_ready=1 -> rx_valid falls.
REQ-034 Frame 0x55 with stop bit forced low -> one frame_err pulse, rx_valid stays 0.
REQ-035 rst_n pulsed low during data bit 4 of 0xFF, then a clean 0x12 frame -> only 0x12 is delivered.
REQ-036 RAY_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> one parity_err pulse, no rx_valid; with parity bit 1 -> 0x07 is delivered.
